ifetch_ctrl: RTL and testbench

//  Instruction-fetch controller: owns the PC, drives the read-only instruction memory's

---
 rtl/riscv_defs_pkg.sv | 20 ++
 rtl/ifetch_ctrl_fetch_fifo.sv | 63 ++++++
 rtl/ifetch_ctrl.sv | 93 +++++++++
 tb/tb_ifetch_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/riscv_defs_pkg.sv
// Shared fetch-path definitions: widths, imem size, reset defaults, the FIFO entry and FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: NB_ADDR/NB_INSTR fix the width of fetch_entry_t and therefore of every fetch-path bus.
package riscv_defs;

   localparam int NB_ADDR         = 32;
   localparam int NB_INSTR        = 32;
   localparam int MEM_SIZE        = 256;   // imem size in bytes
   localparam int FETCH_DEPTH_DEF = 2;
   localparam logic [NB_ADDR-1:0] RESET_PC_DEF = '0;

   typedef struct packed {
      logic [NB_ADDR-1:0]  pc;
      logic [NB_INSTR-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {FETCH, FAULT} ifetch_state_t;

endpackage

// File: rtl/ifetch_ctrl_fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t with flush.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: a push is dropped when the FIFO is full, unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high); push/pop/flush, wdata in; rdata (head), full, count out.
module fetch_fifo
   import riscv_defs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             rdata,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CNT_FULL);
   assign do_pop  = pop && (cnt != '0);
   // A simultaneous pop frees the slot the push needs, so full does not block it.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         // Entries are cleared so the head reads as zero straight out of reset.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, reads imem combinationally and queues words toward decode.
// Latency: a word read in cycle N reaches decode in N+1 if the FIFO is empty; a redirect adds a 2-cycle bubble.
// Backpressure: when the FIFO is full and decode stalls, the PC and imem address hold.
// Ports: clk, rst (sync, active-high); imem_pc out / imem_instr in; redir_valid/redir_pc in;
//        dec_valid/dec_instr/dec_pc out with dec_ready in; fetch_fault out.
module ifetch_ctrl
   import riscv_defs::*;
#(
   parameter logic [NB_ADDR-1:0] RESET_PC    = RESET_PC_DEF,
   parameter int                 FETCH_DEPTH = FETCH_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   output logic [NB_ADDR-1:0]  imem_pc,
   input  logic [NB_INSTR-1:0] imem_instr,
   input  logic                redir_valid,
   input  logic [NB_ADDR-1:0]  redir_pc,
   output logic                dec_valid,
   input  logic                dec_ready,
   output logic [NB_INSTR-1:0] dec_instr,
   output logic [NB_ADDR-1:0]  dec_pc,
   output logic                fetch_fault
);

   ifetch_state_t                 state;
   logic [NB_ADDR-1:0]            pc;
   logic [NB_ADDR:0]              pc_last_byte;
   logic                          pc_bad;
   logic                          pop;
   logic                          push;
   logic                          fifo_full;
   logic [$clog2(FETCH_DEPTH):0]  fifo_cnt;
   fetch_entry_t                  wr_entry;
   fetch_entry_t                  head;

   assign imem_pc = pc;

   // One extra bit so the last-byte address cannot wrap around the range check.
   assign pc_last_byte = {1'b0, pc} + (NB_ADDR+1)'(3);
   assign pc_bad       = (pc[1:0] != 2'b00) || (pc_last_byte >= (NB_ADDR+1)'(MEM_SIZE));

   assign pop  = dec_valid && dec_ready;
   assign push = (state == FETCH) && !redir_valid && !pc_bad && (!fifo_full || pop);

   assign wr_entry.pc    = pc;
   assign wr_entry.instr = imem_instr;

   fetch_fifo #(.DEPTH(FETCH_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop && !redir_valid),   // a redirect discards the head instead of handing it over
      .flush (redir_valid),
      .wdata (wr_entry),
      .rdata (head),
      .full  (fifo_full),
      .count (fifo_cnt)
   );

   assign dec_valid = (fifo_cnt != '0);
   assign dec_instr = head.instr;
   assign dec_pc    = head.pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         fetch_fault <= 1'b0;
      end else if (redir_valid) begin
         // Target legality is evaluated on the following cycle, back in FETCH.
         state       <= FETCH;
         pc          <= redir_pc;
         fetch_fault <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (pc_bad) begin
                  state       <= FAULT;
                  fetch_fault <= 1'b1;
               end else if (push) begin
                  pc <= pc + NB_ADDR'(4);
               end
            end
            FAULT: begin
               // Halted until a redirect or reset; queued entries still drain.
               fetch_fault <= 1'b1;
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: imem[i]=i, inputs driven 1 time unit after posedge,
// outputs checked right after that drive point, expected values hand-derived per cycle.
module tb_ifetch_ctrl;
   import riscv_defs::*;

   logic                clk = 1'b0;
   logic                rst;
   logic [NB_ADDR-1:0]  imem_pc;
   logic [NB_INSTR-1:0] imem_instr;
   logic                redir_valid;
   logic [NB_ADDR-1:0]  redir_pc;
   logic                dec_valid;
   logic                dec_ready;
   logic [NB_INSTR-1:0] dec_instr;
   logic [NB_ADDR-1:0]  dec_pc;
   logic                fetch_fault;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Word-indexed imem holding its own index.
   assign imem_instr = imem_pc >> 2;

   ifetch_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .imem_pc     (imem_pc),
      .imem_instr  (imem_instr),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_instr   (dec_instr),
      .dec_pc      (dec_pc),
      .fetch_fault (fetch_fault)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redir_valid = 1'b0; redir_pc = '0; dec_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] exp_pc);
      chk({tag, "_vld"}, 32'(dec_valid), 32'd1);
      chk({tag, "_pc"}, dec_pc, exp_pc);
      chk({tag, "_instr"}, dec_instr, exp_pc >> 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset state and streaming at one word per cycle
      do_reset();
      chk("rst_vld", 32'(dec_valid), 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_imem_pc", imem_pc, 32'h0);
      chk("rst_dec_pc", dec_pc, 32'h0);
      chk("rst_dec_instr", dec_instr, 32'h0);
      dec_ready = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk_head("stream", 32'(4 * (k - 1)));
         chk("stream_fault", 32'(fetch_fault), 32'd0);
      end

      // 2: stall until full, PC holds, head stable, then release without loss/duplication
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_head("stall", 32'h0);
      end
      chk("stall_imem_pc", imem_pc, 32'h8);
      dec_ready = 1'b1;
      tick(); chk_head("rel0", 32'h4);
      tick(); chk_head("rel1", 32'h8);
      tick(); chk_head("rel2", 32'hC);

      // 3: redirect while full with dec_ready=1
      do_reset();
      tick(); tick();
      chk("full_imem_pc", imem_pc, 32'h8);
      dec_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h40;
      tick();
      redir_valid = 1'b0;
      chk("redir_bubble_vld", 32'(dec_valid), 32'd0);
      chk("redir_imem_pc", imem_pc, 32'h40);
      tick(); chk_head("redir_t0", 32'h40);
      tick(); chk_head("redir_t1", 32'h44);

      // 4: misaligned redirect faults, a legal redirect clears it
      redir_valid = 1'b1; redir_pc = 32'h42;
      tick();
      redir_valid = 1'b0;
      chk("mis_vld0", 32'(dec_valid), 32'd0);
      tick();
      chk("mis_fault", 32'(fetch_fault), 32'd1);
      chk("mis_vld1", 32'(dec_valid), 32'd0);
      chk("mis_imem_pc", imem_pc, 32'h42);
      tick();
      chk("mis_vld2", 32'(dec_valid), 32'd0);
      redir_valid = 1'b1; redir_pc = 32'h44;
      tick();
      redir_valid = 1'b0;
      chk("clr_fault", 32'(fetch_fault), 32'd0);
      chk("clr_vld", 32'(dec_valid), 32'd0);
      tick(); chk_head("clr_t0", 32'h44);

      // 5: run up to the last legal word, fault at MEM_SIZE, queued words drain
      dec_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'(MEM_SIZE - 8);
      tick();
      redir_valid = 1'b0;
      tick(); tick(); tick();
      chk("end_fault", 32'(fetch_fault), 32'd1);
      chk("end_imem_pc", imem_pc, 32'(MEM_SIZE));
      chk_head("end_h0", 32'(MEM_SIZE - 8));
      dec_ready = 1'b1;
      tick();
      chk_head("end_h1", 32'(MEM_SIZE - 4));
      chk("end_fault1", 32'(fetch_fault), 32'd1);
      tick();
      chk("end_drained", 32'(dec_valid), 32'd0);
      chk("end_fault2", 32'(fetch_fault), 32'd1);

      // 6: reset with FIFO full and fault set; reset beats a concurrent redirect
      dec_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'(MEM_SIZE - 8);
      tick();
      redir_valid = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_fault", 32'(fetch_fault), 32'd1);
      chk("pre_rst_vld", 32'(dec_valid), 32'd1);
      rst = 1'b1; redir_valid = 1'b1; redir_pc = 32'h80; dec_ready = 1'b1;
      tick();
      rst = 1'b0; redir_valid = 1'b0;
      chk("mid_rst_vld", 32'(dec_valid), 32'd0);
      chk("mid_rst_fault", 32'(fetch_fault), 32'd0);
      chk("mid_rst_imem_pc", imem_pc, 32'h0);
      chk("mid_rst_dec_pc", dec_pc, 32'h0);
      tick(); chk_head("post_rst", 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
